// File: rtl/alu_input_pkg.sv
// rtl/alu_input_pkg.sv - shared state encoding and widths for the calculator input path
//
// Purpose: one-hot state encoding and data widths shared by the operand-entry
// FSM and the display-control block that decodes its state bus.
// Ports: none (package).

package alu_input_pkg;

  localparam int OPERAND_W  = 16;
  localparam int ALU_CTRL_W = 3;

  // One-hot so the display block can select on a single bit per state.
  typedef enum logic [3:0] {
    ST_WAIT_OP1    = 4'b0001,
    ST_WAIT_OP2    = 4'b0010,
    ST_WAIT_OPCODE = 4'b0100,
    ST_SHOW_RESULT = 4'b1000
  } state_t;

endpackage

// File: rtl/btn_debouncer.sv
// rtl/btn_debouncer.sv - synchroniser, debouncer and rising-edge detector for one raw button
//
// Purpose: condition a raw asynchronous push-button into a clean level and a
// single-cycle press pulse.
// Ports:
//   clk    in  : system clock
//   rst_n  in  : asynchronous active-low reset
//   raw    in  : raw button pin, asynchronous to clk
//   level  out : debounced button level
//   pulse  out : one-cycle pulse on each accepted press (rising edge only)

module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The level flips on the edge where the counter would have reached
  // DEBOUNCE_CYCLES, so the count itself never exceeds DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             deb;
  logic             deb_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      // Any sample that agrees with the accepted level restarts the count,
      // so bounces shorter than DEBOUNCE_CYCLES never flip the level.
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= ~deb;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = deb;
  assign pulse = deb & ~deb_q;

endmodule

// File: rtl/alu_input_fsm.sv
// rtl/alu_input_fsm.sv - operand-entry FSM for the calculator front end
//
// Purpose: steps the user through entering operand 1, operand 2 and the
// opcode from the board switches using an enter (BTNC) and back (BTNL)
// button, and drives the captured values plus a one-hot state bus.
// Optional feature macro: ALU_INPUT_LIVE_PREVIEW_EN - when defined, the
// register belonging to the current entry state follows SW every cycle.
// Ports:
//   CLK100MHZ    in      : 100 MHz system clock
//   CPU_RESETN   in      : asynchronous active-low reset
//   SW           in [16] : raw switches, operand/opcode data (quasi-static)
//   BTNC         in      : raw enter button, active-high
//   BTNL         in      : raw back button, active-high
//   OP1          out[16] : captured operand 1
//   OP2          out[16] : captured operand 2
//   ALU_ctrl     out[3]  : captured operation code (SW[2:0])
//   state        out[4]  : one-hot FSM state
//   result_valid out     : high while in SHOW_RESULT

module alu_input_fsm
  import alu_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  CLK100MHZ,
  input  logic                  CPU_RESETN,
  input  logic [OPERAND_W-1:0]  SW,
  input  logic                  BTNC,
  input  logic                  BTNL,
  output logic [OPERAND_W-1:0]  OP1,
  output logic [OPERAND_W-1:0]  OP2,
  output logic [ALU_CTRL_W-1:0] ALU_ctrl,
  output logic [3:0]            state,
  output logic                  result_valid
);

  logic   enter_p;
  logic   back_p;
  logic   enter_lvl;
  logic   back_lvl;
  state_t state_q;

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_enter (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .raw   (BTNC),
    .level (enter_lvl),
    .pulse (enter_p)
  );

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_back (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .raw   (BTNL),
    .level (back_lvl),
    .pulse (back_p)
  );

  // Debounced levels are not needed here; only the press pulses drive the FSM.
  logic unused_levels;
  assign unused_levels = enter_lvl ^ back_lvl;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q  <= ST_WAIT_OP1;
      OP1      <= '0;
      OP2      <= '0;
      ALU_ctrl <= '0;
    end else begin
`ifdef ALU_INPUT_LIVE_PREVIEW_EN
      // Live tracking of the register being entered; an enter capture below
      // loads the same SW value and the state change then freezes it.
      case (state_q)
        ST_WAIT_OP1:    OP1      <= SW;
        ST_WAIT_OP2:    OP2      <= SW;
        ST_WAIT_OPCODE: ALU_ctrl <= SW[ALU_CTRL_W-1:0];
        default:        ;
      endcase
`endif
      // Simultaneous enter and back cancel each other.
      if (enter_p && !back_p) begin
        case (state_q)
          ST_WAIT_OP1: begin
            OP1     <= SW;
            state_q <= ST_WAIT_OP2;
          end
          ST_WAIT_OP2: begin
            OP2     <= SW;
            state_q <= ST_WAIT_OPCODE;
          end
          ST_WAIT_OPCODE: begin
            ALU_ctrl <= SW[ALU_CTRL_W-1:0];
            state_q  <= ST_SHOW_RESULT;
          end
          default: state_q <= ST_WAIT_OP1;
        endcase
      end else if (back_p && !enter_p) begin
        case (state_q)
          ST_WAIT_OP2:    state_q <= ST_WAIT_OP1;
          ST_WAIT_OPCODE: state_q <= ST_WAIT_OP2;
          ST_SHOW_RESULT: state_q <= ST_WAIT_OPCODE;
          default:        state_q <= ST_WAIT_OP1;
        endcase
      end
    end
  end

  assign state        = state_q;
  assign result_valid = (state_q == ST_SHOW_RESULT);

endmodule

// File: tb/tb_alu_input_fsm.sv
// tb/tb_alu_input_fsm.sv - scoreboard bench for alu_input_fsm

module tb_alu_input_fsm;
  import alu_input_pkg::*;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = '0;
  logic        btnc = 1'b0;
  logic        btnl = 1'b0;
  logic [15:0] op1;
  logic [15:0] op2;
  logic [2:0]  alu_ctrl;
  logic [3:0]  state;
  logic        result_valid;

  alu_input_fsm #(.DEBOUNCE_CYCLES(DEB)) dut (
    .CLK100MHZ    (clk),
    .CPU_RESETN   (rst_n),
    .SW           (sw),
    .BTNC         (btnc),
    .BTNL         (btnl),
    .OP1          (op1),
    .OP2          (op2),
    .ALU_ctrl     (alu_ctrl),
    .state        (state),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] st;
    int         edge_no;
  } adv_t;

  adv_t       sb[$];
  int         edge_cnt = 0;
  logic       mon_en = 1'b0;
  logic [3:0] last_state = 4'b0001;

  // reference model
  logic [3:0]  m_state = 4'b0001;
  logic [15:0] m_op1 = '0;
  logic [15:0] m_op2 = '0;
  logic [2:0]  m_ctrl = '0;

  always @(posedge clk) edge_cnt++;

  // Every observed state change must match the oldest expected advance.
  always @(negedge clk) begin
    if (mon_en && state !== last_state) begin
      if (sb.size() == 0) begin
        check("unexpected_adv", {28'd0, state}, {28'd0, last_state});
      end else begin
        adv_t e;
        e = sb.pop_front();
        check("adv_state", {28'd0, state}, {28'd0, e.st});
        check("adv_edge", edge_cnt, e.edge_no);
      end
      last_state = state;
    end
  end

  task automatic model_enter();
    case (m_state)
      4'b0001: begin m_op1 = sw; m_state = 4'b0010; end
      4'b0010: begin m_op2 = sw; m_state = 4'b0100; end
      4'b0100: begin m_ctrl = sw[2:0]; m_state = 4'b1000; end
      default: m_state = 4'b0001;
    endcase
  endtask

  task automatic model_back();
    case (m_state)
      4'b0010: m_state = 4'b0001;
      4'b0100: m_state = 4'b0010;
      4'b1000: m_state = 4'b0100;
      default: m_state = 4'b0001;
    endcase
  endtask

  task automatic check_regs(input string tag);
`ifdef ALU_INPUT_LIVE_PREVIEW_EN
    case (m_state)
      4'b0001: m_op1  = sw;
      4'b0010: m_op2  = sw;
      4'b0100: m_ctrl = sw[2:0];
      default: ;
    endcase
`endif
    check({tag, "_state"}, {28'd0, state}, {28'd0, m_state});
    check({tag, "_op1"}, {16'd0, op1}, {16'd0, m_op1});
    check({tag, "_op2"}, {16'd0, op2}, {16'd0, m_op2});
    check({tag, "_ctrl"}, {29'd0, alu_ctrl}, {29'd0, m_ctrl});
    check({tag, "_rv"}, {31'd0, result_valid}, {31'd0, (m_state == 4'b1000)});
  endtask

  task automatic push_adv(input logic is_enter);
    adv_t e;
    if (is_enter) model_enter(); else model_back();
    e.st = m_state;
    e.edge_no = edge_cnt + DEB + 3;
    if (m_state != last_state || sb.size() != 0) sb.push_back(e);
  endtask

  // Clean press and release of one button; SW must already be set.
  task automatic press(input logic is_enter, input string tag);
    @(posedge clk); #1;
    if (is_enter) btnc = 1'b1; else btnl = 1'b1;
    push_adv(is_enter);
    repeat (DEB + 5) @(posedge clk);
    #1;
    btnc = 1'b0;
    btnl = 1'b0;
    repeat (DEB + 6) @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_state = 4'b0001; m_op1 = '0; m_op2 = '0; m_ctrl = '0;
    last_state = 4'b0001;
    mon_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    do_reset();
    check_regs("reset");

    // full entry sequence
    sw = 16'h1234; press(1'b1, "e1");
    sw = 16'h00FF; press(1'b1, "e2");
    sw = 16'h0002; press(1'b1, "e3");
    check("full_op1", {16'd0, op1}, 32'h1234);
    check("full_op2", {16'd0, op2}, 32'h00FF);
    check("full_ctrl", {29'd0, alu_ctrl}, 32'd2);
    check("full_state", {28'd0, state}, 32'h8);

    // back navigation, fourth press stays in WAIT_OP1
    for (int i = 0; i < 4; i++) press(1'b0, "back");
    check("back_final", {28'd0, state}, {28'd0, ST_WAIT_OP1});

    // bounce rejection, then settle high
    sw = 16'h5555;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      btnc = (i % 2 == 0);
      repeat (2) @(posedge clk);
      #1;
    end
    btnc = 1'b1;
    push_adv(1'b1);
    repeat (DEB + 8) @(posedge clk);
    #1;
    btnc = 1'b0;
    repeat (DEB + 8) @(posedge clk);
    #1;
    check_regs("bounce");

    // simultaneous enter and back in WAIT_OP2
    sw = 16'h7777;
    @(posedge clk); #1;
    btnc = 1'b1;
    btnl = 1'b1;
    repeat (DEB + 6) @(posedge clk);
    #1;
    btnc = 1'b0;
    btnl = 1'b0;
    repeat (DEB + 6) @(posedge clk);
    #1;
    check_regs("simul");

    // reach WAIT_OPCODE then reset asynchronously
    sw = 16'h0BEE; press(1'b1, "to_opc");
    check("pre_rst_state", {28'd0, state}, {28'd0, ST_WAIT_OPCODE});
    mon_en = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", {28'd0, state}, 32'h1);
    check("arst_op1", {16'd0, op1}, 32'h0);
    check("arst_op2", {16'd0, op2}, 32'h0);
    check("arst_ctrl", {29'd0, alu_ctrl}, 32'h0);
    check("arst_rv", {31'd0, result_valid}, 32'h0);
    do_reset();

`ifdef ALU_INPUT_LIVE_PREVIEW_EN
    @(posedge clk); #1;
    sw = 16'hABCD;
    @(posedge clk); #1;
    check("live_op1", {16'd0, op1}, 32'hABCD);
    press(1'b1, "live_enter");
    sw = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("live_frozen", {16'd0, op1}, 32'hABCD);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_input_fsm.md
# alu_input_fsm

Operand-entry front end for the S7 calculator: reads the 16 board switches and two raw push-buttons, steps the user through entering operand 1, operand 2 and the operation code, and drives `OP1`, `OP2`, `ALU_ctrl` and the one-hot `state` bus consumed by the ALU/display top level. It is the producer side of that top level's input interface. It includes per-button synchronisation, debouncing and edge detection, so raw board pins connect directly.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000, consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz).
- `CLK100MHZ` in 1: system clock, 100 MHz.
- `CPU_RESETN` in 1: one clock; reset is asynchronous and active-low.
- `SW` in 16: raw switches, sampled as operand/opcode data.
- `BTNC` in 1: raw "enter" button, active-high, asynchronous to clock.
- `BTNL` in 1: raw "back" button, active-high, asynchronous to clock.
- `OP1` out 16: captured operand 1.
- `OP2` out 16: captured operand 2.
- `ALU_ctrl` out 3: captured operation code (`SW[2:0]`).
- `state` out 4: one-hot FSM state for display selection.
- `result_valid` out 1: high while in SHOW_RESULT.

## Operation
- States, with their one-hot `state` value:
  - WAIT_OP1 = 4'b0001
  - WAIT_OP2 = 4'b0010
  - WAIT_OPCODE = 4'b0100
  - SHOW_RESULT = 4'b1000
- Enter pulse transitions:
  - WAIT_OP1 → WAIT_OP2, with `OP1 <= SW`.
  - WAIT_OP2 → WAIT_OPCODE, with `OP2 <= SW`.
  - WAIT_OPCODE → SHOW_RESULT, with `ALU_ctrl <= SW[2:0]`.
  - SHOW_RESULT → WAIT_OP1. No register changes.
- Back pulse transitions:
  - WAIT_OP2 → WAIT_OP1.
  - WAIT_OPCODE → WAIT_OP2.
  - SHOW_RESULT → WAIT_OPCODE.
  - WAIT_OP1 stays in WAIT_OP1.
  - Back never modifies `OP1`, `OP2` or `ALU_ctrl`.
- Enter and back pulses in the same cycle: no state change and no capture.
- Captured values hold until overwritten by a later capture. There is no clearing on a return to WAIT_OP1.
- Per-button conditioning, in order:
  - Two-flop synchroniser.
  - Debounce counter: increments while the synchronised level ≠ debounced level, clears when they are equal. When the count reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - Registered rising-edge detector: pulse = deb & ~deb_q, exactly one cycle wide per press.
- Release edges generate no pulse. Bounces shorter than `DEBOUNCE_CYCLES` cycles are ignored entirely.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`; it must never wrap.

## Timing
- Reset values:
  - `OP1` = 0, `OP2` = 0, `ALU_ctrl` = 0.
  - `state` = 4'b0001, `result_valid` = 0.
  - All synchroniser, debounce and edge flops = 0.
- Reset mid-entry: returns immediately to WAIT_OP1 with all outputs cleared.
- A button still held through reset release is treated as a new press after the normal debounce delay.
- Latency from a stable high level on a raw button to the `state`/register update:
  - 2 synchroniser cycles.
  - `DEBOUNCE_CYCLES` counter cycles.
  - 1 edge-register cycle.
  - Total: `DEBOUNCE_CYCLES` + 3 rising edges.
- Capture samples `SW` on the same edge at which `state` advances. `SW` is not synchronised (quasi-static); the captured value is whatever is present at that edge.
- All outputs are registered. `result_valid` is decoded from the state register, so it carries no extra cycle.

## Configuration
- `ALU_INPUT_LIVE_PREVIEW_EN` defined:
  - In WAIT_OP1, `OP1` follows `SW` every cycle (registered, 1-cycle lag).
  - In WAIT_OP2, `OP2` follows `SW` every cycle.
  - In WAIT_OPCODE, `ALU_ctrl` follows `SW[2:0]` every cycle.
  - The enter capture freezes the value.
  - Back into a state resumes live tracking.
- Undefined: registers change only on the enter capture, as described in Operation.

## Structure
- Package `alu_input_pkg` holds:
  - The state encoding constants (`ST_WAIT_OP1` … `ST_SHOW_RESULT`, 4-bit one-hot).
  - `OPERAND_W` = 16 and `ALU_CTRL_W` = 3.
- The display-control block imports the same package for its state decoding.
- Sub-module `btn_debouncer`, parameterised by `DEBOUNCE_CYCLES`, contains the synchroniser, debouncer and edge detector. Ports: clock, async reset, raw in, `level` out, `pulse` out. It is instantiated twice.
- The FSM and capture registers live in the top module.

## Test plan
Simulate with `DEBOUNCE_CYCLES` = 4.
- Reset released, no buttons pressed → `state` = 0001, `OP1` = `OP2` = 0, `ALU_ctrl` = 0, `result_valid` = 0.
- Full entry sequence:
  - `SW` = 16'h1234, press `BTNC`; `SW` = 16'h00FF, press; `SW` = 16'h0002, press.
  - Expect `OP1` = 16'h1234, `OP2` = 16'h00FF, `ALU_ctrl` = 3'b010, `state` = 1000, `result_valid` = 1.
  - Each press advances `state` exactly 7 clock edges after `BTNC` rises.
- Bounce rejection:
  - `BTNC` toggles high/low every 2 cycles for 20 cycles, then settles high.
  - Exactly one state advance, occurring 7 edges after settling. Release produces no advance.
- Back navigation:
  - From SHOW_RESULT, press `BTNL` three times → `state` goes 0100, 0010, 0001; a fourth press stays at 0001.
  - `OP1`/`OP2`/`ALU_ctrl` unchanged throughout.
- Simultaneous and reset cases:
  - Pulses on `BTNC` and `BTNL` in the same cycle while in WAIT_OP2 → `state` stays 0010, `OP2` unchanged.
  - `CPU_RESETN` low while in WAIT_OPCODE → outputs return to reset values asynchronously.
- With `ALU_INPUT_LIVE_PREVIEW_EN`:
  - In WAIT_OP1, change `SW` to 16'hABCD → `OP1` = 16'hABCD one cycle later.
  - After enter, changing `SW` to 0 leaves `OP1` = 16'hABCD.
